// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath constants and collector state type
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int KERNEL = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } collect_state_t;

endpackage

// File: rtl/output_collect_4x4_if.sv
// rtl/output_collect_4x4_if.sv - sample-in / element-out stream bundle of the output collector
interface output_collect_4x4_if;
  import cnn_pkg::*;

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;
  logic                     out_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output out_valid, out_data, out_last
  );

endinterface

// File: rtl/ofmap_buf.sv
// rtl/ofmap_buf.sv - output-map register file, one synchronous write port, one registered read port
module ofmap_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = 9,
  parameter int AW    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [AW-1:0]            rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  // storage write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // registered read, only advances when the consumer asks for the next element
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/output_collect_4x4.sv
// rtl/output_collect_4x4.sv - collects a systolic-array output map and drains it as a ready/valid stream (option: OUTPUT_RELU_EN)
module output_collect_4x4
  import cnn_pkg::*;
#(
  parameter logic [5:0] IMG = 6'd6,
  parameter logic [5:0] PAD = 6'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output_collect_4x4_if.slave  bus,
  output logic                 done,
  output logic                 err
);

  localparam int SIZE  = int'(IMG) + 2 * int'(PAD);
  localparam int OUT   = SIZE - (KERNEL - 1);
  localparam int DEPTH = OUT * OUT;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  collect_state_t           state;
  logic [CNT_W-1:0]         wr_cnt;
  logic [CNT_W-1:0]         rd_cnt;
  logic                     wr_en;
  logic signed [DATA_W-1:0] wr_data;
  logic                     rd_en;
  logic [CNT_W-1:0]         rd_addr;

  assign wr_en = bus.in_valid && (state == IDLE || state == COLLECT);

  // sample conditioning before storage
  always_comb begin
    wr_data = bus.in_data;
`ifdef OUTPUT_RELU_EN
    if (bus.in_data < 0) wr_data = '0;
`endif
  end

  // fetch element 0 on DRAIN entry, then prefetch the next one on each handshake
  assign rd_en   = (state == DRAIN) &&
                   (!bus.out_valid || (bus.out_ready && !bus.out_last));
  assign rd_addr = bus.out_valid ? rd_cnt + CNT_W'(1) : rd_cnt;

  ofmap_buf #(
    .DEPTH (DEPTH),
    .AW    (CNT_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (bus.out_data)
  );

  // collector FSM with counters and registered stream/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (bus.in_valid) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
            if (bus.in_last || (wr_cnt + CNT_W'(1) == DEPTH_C)) state <= DRAIN;
            else                                               state <= COLLECT;
          end
        end
        DRAIN: begin
          if (bus.in_valid) err <= 1'b1;
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
            bus.out_last  <= (wr_cnt == CNT_W'(1));
          end else if (bus.out_ready) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
            if (bus.out_last) begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              done          <= 1'b1;
              state         <= DONE;
            end else begin
              bus.out_last <= (rd_cnt + CNT_W'(2) == wr_cnt);
            end
          end
        end
        DONE: begin
          if (bus.in_valid) err <= 1'b1;
          done   <= 1'b0;
          wr_cnt <= '0;
          rd_cnt <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_collect_4x4.sv
// tb/tb_output_collect_4x4.sv - self-checking bench for output_collect_4x4
module tb_output_collect_4x4;

  logic clk = 1'b0;
  logic rst_n;
  logic done;
  logic err;

  output_collect_4x4_if bus();

  output_collect_4x4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        il;
    logic        ordy;
    logic        ov;
    logic [15:0] od;
    logic        chkd;
    logic        ol;
    logic        dn;
    logic        er;
  } vec_t;

  vec_t tbl [21];
  int   nvec = 0;
  int   nerr = 0;
  logic [15:0] relu_exp;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_map(input int first, input int n, input bit last_at_end);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(first + i);
      bus.in_last  = last_at_end && (i == n - 1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  // pat 0: always ready, pat 1: ready toggles 1,0,1,0...
  task automatic drain_check(input string name, input int n, input int first, input int pat);
    int          idx = 0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev = '0;
    logic [15:0] e;
    for (int c = 0; c < 200 && idx < n; c++) begin
      @(negedge clk);
      bus.out_ready = (pat == 0) ? 1'b1 : (c % 2 == 0);
      if (prev_stall)
        chk({name, "_stall_hold"}, int'({bus.out_valid, bus.out_last, bus.out_data}), int'(prev));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev       = {bus.out_valid, bus.out_last, bus.out_data};
      if (bus.out_valid && bus.out_ready) begin
        e = 16'(first + idx);
        chk({name, "_data"}, int'({16'd0, bus.out_data}), int'({16'd0, e}));
        chk({name, "_last"}, int'(bus.out_last), int'(idx == n - 1));
        idx++;
      end
    end
    chk({name, "_count"}, idx, n);
    @(negedge clk);
    chk({name, "_done_pulse"}, int'({done, bus.out_valid}), 2);
    @(negedge clk);
    chk({name, "_done_clear"}, int'(done), 0);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    bit ok;
`ifdef OUTPUT_RELU_EN
    relu_exp = 16'h0000;
`else
    relu_exp = 16'hFFFB;
`endif
    for (int k = 0; k < 21; k++) begin
      tbl[k].iv   = (k <= 8);
      tbl[k].id   = (k <= 8) ? 16'(k) : 16'd0;
      tbl[k].il   = (k == 8);
      tbl[k].ordy = 1'b1;
      tbl[k].ov   = (k >= 10 && k <= 18);
      tbl[k].od   = 16'(k - 10);
      tbl[k].chkd = tbl[k].ov;
      tbl[k].ol   = (k == 18);
      tbl[k].dn   = (k == 19);
      tbl[k].er   = 1'b0;
    end

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("reset_state", int'({bus.out_valid, bus.out_last, done, err, bus.out_data}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // full-throughput map 0..8
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      nvec++;
      ok = (bus.out_valid === tbl[k].ov) && (bus.out_last === tbl[k].ol) &&
           (done === tbl[k].dn) && (err === tbl[k].er) &&
           (!tbl[k].chkd || bus.out_data === tbl[k].od);
      if (!ok) begin
        nerr++;
        $display("FAIL vec%0d: got v=%b d=%0h l=%b done=%b err=%b expected v=%b d=%0h l=%b done=%b err=%b",
                 k, bus.out_valid, bus.out_data, bus.out_last, done, err,
                 tbl[k].ov, tbl[k].od, tbl[k].ol, tbl[k].dn, tbl[k].er);
      end
      bus.in_valid  = tbl[k].iv;
      bus.in_data   = tbl[k].id;
      bus.in_last   = tbl[k].il;
      bus.out_ready = tbl[k].ordy;
    end

    // same map with backpressure
    send_map(0, 9, 1'b1);
    drain_check("stall", 9, 0, 1);

    // negative sample, single-element map straight from IDLE
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = -16'sd5;
    bus.in_last  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    drain_check("relu", 1, int'(relu_exp), 0);

    // early in_last
    send_map(10, 4, 1'b1);
    drain_check("early_last", 4, 10, 0);
    chk("err_clean", int'(err), 0);

    // overrun: tenth sample lands in DRAIN
    bus.out_ready = 1'b0;
    send_map(0, 10, 1'b0);
    chk("overrun_err", int'(err), 1);
    drain_check("overrun", 9, 0, 0);
    chk("err_sticky", int'(err), 1);

    // reset mid-DRAIN after three handshakes
    send_map(0, 9, 1'b1);
    bus.out_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 50 && hs < 3; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) hs++;
    end
    chk("pre_reset_hs", hs, 3);
    @(posedge clk);
    #2;
    chk("pre_reset_elem", int'({16'd0, bus.out_data}), 3);
    rst_n = 1'b0;
    #1;
    chk("async_reset", int'({bus.out_valid, bus.out_last, done, err, bus.out_data}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_map(20, 9, 1'b1);
    drain_check("after_reset", 9, 20, 0);
    chk("err_final", int'(err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/output_collect_4x4.md
OUTPUT_COLLECT_4X4 -- requirements
Module: output_collect_4x4

Interface
REQ-001 Parameter IMG, default 6'd6, input image edge length in pixels.
REQ-002 Parameter PAD, default 6'd0, zero-padding per side; SIZE = IMG + 2*PAD; OUT = SIZE - 3 (4x4 kernel, stride 1); DEPTH = OUT*OUT.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  one result sample present from the systolic array this cycle.
REQ-006 in_data  input  16  signed result sample (array `result`).
REQ-007 in_last  input  1  end-of-map marker (array `end_sig`); qualified by in_valid.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_valid  output  1  out_data holds a valid output-map element.
REQ-010 out_data  output  16  signed output-map element, raster order.
REQ-011 out_last  output  1  high with the final drained element.
REQ-012 done  output  1  one-cycle pulse after the final handshake.
REQ-013 err  output  1  sticky protocol-error flag.

Function
REQ-014 FSM states SHALL be IDLE, COLLECT, DRAIN, DONE.
REQ-015 IDLE -> COLLECT on the first in_valid; that sample SHALL be stored at address 0.
REQ-016 In COLLECT each in_valid SHALL write in_data to buffer[wr_cnt], then wr_cnt += 1; no stall, no backpressure to the array.
REQ-017 COLLECT -> DRAIN after the write when in_valid && in_last, or when wr_cnt reaches DEPTH; drain length = number of stored samples.
REQ-018 in_last with zero prior samples (in IDLE) SHALL store that one sample and go straight to DRAIN with length 1.
REQ-019 in_valid in DRAIN or DONE SHALL be dropped and SHALL set err.
REQ-020 DRAIN: out_valid SHALL rise exactly one cycle after entering DRAIN (registered buffer read).
REQ-021 Handshake completes when out_valid && out_ready; rd_cnt += 1 and next element presented the following cycle, allowing one element per cycle at full throughput.
REQ-022 While out_valid && !out_ready, out_data, out_last, out_valid SHALL hold stable.
REQ-023 out_last SHALL be high only with element (length-1).
REQ-024 After the out_last handshake: DRAIN -> DONE, done = 1 for exactly that one cycle, out_valid = 0; DONE -> IDLE next cycle, counters cleared.
REQ-025 Counters SHALL be sized $clog2(DEPTH+1) bits; no wrap-around permitted.

Reset
REQ-026 On rst_n low, immediately: state = IDLE, wr_cnt = rd_cnt = 0, out_valid = 0, out_data = 0, out_last = 0, done = 0, err = 0.
REQ-027 Reset mid-COLLECT or mid-DRAIN SHALL abandon the map; buffer contents are not reset and are never presented before being rewritten.
REQ-028 err SHALL clear only on reset.

Configuration
REQ-029 Macro OUTPUT_RELU_EN: when defined, each sample SHALL be written as max(in_data, 0); when undefined, in_data is stored unmodified.

Structure
REQ-030 Shared package cnn_pkg SHALL hold DATA_W = 16, KERNEL = 4, and the collector state enumeration.
REQ-031 Buffer SHALL be a sub-module ofmap_buf: DEPTH x 16 register file, one synchronous write port, one registered read port.

Verification
REQ-032 IMG=6, PAD=0, samples 0..8, in_last on 8, out_ready=1 -> out_data 0..8 on consecutive cycles, out_last with 8, done one cycle later, err=0.
REQ-033 Same stream, out_ready toggling 1,0,1,0 -> every element delivered once in order, out_data stable across each stalled cycle.
REQ-034 Sample -5 -> out_data 0 with OUTPUT_RELU_EN, 0xFFFB without.
REQ-035 Early in_last on 4th sample (values 10..13) -> exactly 4 outputs 10..13, out_last on 13.
REQ-036 Ten samples without in_last -> auto-DRAIN after 9th, 10th dropped, err=1, outputs 0..8.
REQ-037 rst_n low mid-DRAIN after 3 handshakes -> all outputs 0 immediately; new 9-sample map then drains correctly from element 0.
